mfc_stimulus_gen: RTL and testbench

Sequential operand generator that drives the 16-bit multi-function comparator (MFC). It accepts an operand A and a requested relation, builds a matching operand B one bit per cycle, and computes the flags the comparator must return for (A, B): EQ, AE, GT and d. The generator and the comparator form a closed loop: this block produces the stimulus and the expected response, and the comparator is checked against them. All arithmetic is 16-bit two's complement.

---
 rtl/mfc_stimulus_gen.sv | 151 +++++++++++++++
 tb/tb_mfc_stimulus_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfc_stimulus_gen.sv
// rtl/mfc_stimulus_gen.sv - operand B generator and expected-flag model for the 16-bit MFC
// Optional MFC_GEN_LFSR_EN: pseudo-random filler bits from a 16-bit LFSR (otherwise filler is 0).
module mfc_stimulus_gen #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [1:0]  in_mode,
   input  logic [3:0]  in_d,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_a,
   output logic [15:0] out_b,
   output logic        exp_eq,
   output logic        exp_ae,
   output logic        exp_gt,
   output logic [3:0]  exp_d
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BUILD = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [1:0] M_EQ   = 2'b00;
   localparam logic [1:0] M_NEG  = 2'b01;
   localparam logic [1:0] M_DIFF = 2'b10;

   logic [1:0]  r_state;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [1:0]  r_mode;
   logic [3:0]  r_d;
   logic [3:0]  r_cnt;
   logic [3:0]  r_exp_d;
   logic        r_carry;
   logic        r_diff_seen;
   logic        r_eq;
   logic        r_ae;
   logic        r_gt;

   logic        w_fill;
   logic        w_ai;
   logic        w_bit;
   logic [15:0] w_abs_a;
   logic [15:0] w_abs_b;

`ifdef MFC_GEN_LFSR_EN
   logic [15:0] r_lfsr;

   // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right into bit 15.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lfsr <= SEED;
      end else if (r_state == S_BUILD) begin
         r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      end
   end

   assign w_fill = r_lfsr[0];
`else
   logic w_unused_seed;
   assign w_unused_seed = ^SEED;
   assign w_fill        = 1'b0;
`endif

   assign w_ai = r_a[r_cnt];

   always_comb begin
      w_bit = w_fill;
      case (r_mode)
         M_EQ:    w_bit = w_ai;
         M_NEG:   w_bit = ~w_ai ^ r_carry;
         M_DIFF: begin
            if (r_cnt > r_d)       w_bit = w_ai;
            else if (r_cnt == r_d) w_bit = ~w_ai;
            else                   w_bit = w_fill;
         end
         default: w_bit = w_fill;
      endcase
   end

   // Magnitudes wrap at 16 bits, so |0x8000| stays 0x8000.
   assign w_abs_a = r_a[15] ? (~r_a + 16'd1) : r_a;
   assign w_abs_b = r_b[15] ? (~r_b + 16'd1) : r_b;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= 16'd0;
         r_b         <= 16'd0;
         r_mode      <= M_EQ;
         r_d         <= 4'd0;
         r_cnt       <= 4'd0;
         r_exp_d     <= 4'd0;
         r_carry     <= 1'b1;
         r_diff_seen <= 1'b0;
         r_eq        <= 1'b0;
         r_ae        <= 1'b0;
         r_gt        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a         <= in_a;
                  r_mode      <= in_mode;
                  r_d         <= in_d;
                  r_b         <= 16'd0;
                  r_exp_d     <= 4'd0;
                  r_diff_seen <= 1'b0;
                  r_carry     <= 1'b1;
                  r_cnt       <= 4'd0;
                  r_state     <= S_BUILD;
               end
            end
            S_BUILD: begin
               r_b[r_cnt] <= w_bit;
               if (w_bit != w_ai) begin
                  r_exp_d     <= r_cnt;
                  r_diff_seen <= 1'b1;
               end
               if (r_mode == M_NEG) r_carry <= ~w_ai & r_carry;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'd15) r_state <= S_CHECK;
            end
            S_CHECK: begin
               r_eq    <= ~r_diff_seen;
               r_ae    <= (w_abs_a == w_abs_b);
               r_gt    <= ($signed(r_a) > $signed(r_b));
               r_state <= S_DONE;
            end
            default: begin
               if (out_ready) r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign out_a     = r_a;
   assign out_b     = r_b;
   assign exp_eq    = r_eq;
   assign exp_ae    = r_ae;
   assign exp_gt    = r_gt;
   assign exp_d     = r_exp_d;

endmodule

// File: tb/tb_mfc_stimulus_gen.sv
// tb/tb_mfc_stimulus_gen.sv - scoreboard bench for mfc_stimulus_gen
module tb_mfc_stimulus_gen;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        eq;
      logic        ae;
      logic        gt;
      logic [3:0]  d;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = 16'd0;
   logic [1:0]  in_mode = 2'd0;
   logic [3:0]  in_d = 4'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_a;
   logic [15:0] out_b;
   logic        exp_eq;
   logic        exp_ae;
   logic        exp_gt;
   logic [3:0]  exp_d;

   int checks = 0;
   int errors = 0;
   res_t q[$];
`ifdef MFC_GEN_LFSR_EN
   logic [15:0] m_lfsr = 16'hACE1;
`endif

   mfc_stimulus_gen dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_mode(in_mode), .in_d(in_d), .out_valid(out_valid),
      .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .exp_eq(exp_eq),
      .exp_ae(exp_ae), .exp_gt(exp_gt), .exp_d(exp_d)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   function automatic logic [15:0] abs16(input logic [15:0] x);
      return x[15] ? (16'd0 - x) : x;
   endfunction

   function automatic res_t mk(input logic [15:0] a, input logic [15:0] b);
      res_t r;
      r.a  = a;
      r.b  = b;
      r.eq = (a == b);
      r.ae = (abs16(a) == abs16(b));
      r.gt = ($signed(a) > $signed(b));
      r.d  = 4'd0;
      for (int i = 0; i < 16; i++) if (a[i] != b[i]) r.d = 4'(i);
      return r;
   endfunction

   task automatic lfsr_advance();
`ifdef MFC_GEN_LFSR_EN
      for (int i = 0; i < 16; i++)
         m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
   endtask

   task automatic model_push(input logic [15:0] a, input logic [1:0] mode, input logic [3:0] d);
      logic [15:0] b;
      logic [15:0] fill;
`ifdef MFC_GEN_LFSR_EN
      logic [15:0] l;
      l = m_lfsr;
      for (int i = 0; i < 16; i++) begin
         fill[i] = l[0];
         l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
      end
`else
      fill = 16'd0;
`endif
      case (mode)
         2'b00: b = a;
         2'b01: b = 16'd0 - a;
         2'b10: for (int i = 0; i < 16; i++)
                   b[i] = (i > int'(d)) ? a[i] : ((i == int'(d)) ? ~a[i] : fill[i]);
         default: b = fill;
      endcase
      lfsr_advance();
      q.push_back(mk(a, b));
   endtask

   task automatic push_const(input res_t r);
      lfsr_advance();
      q.push_back(r);
   endtask

   task automatic issue(input logic [15:0] a, input logic [1:0] mode, input logic [3:0] d);
      int n;
      in_valid = 1'b1;
      in_a     = a;
      in_mode  = mode;
      in_d     = d;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic collect(output res_t got, output int lat);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      got = {out_a, out_b, exp_eq, exp_ae, exp_gt, exp_d};
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic pop_exp(output res_t e);
      if (q.size() > 0) e = q.pop_front();
      else e = '1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_a, out_b, exp_eq, exp_ae, exp_gt, exp_d} !== {1'b1, 1'b0, 39'd0}) begin
         errors++;
         $display("FAIL reset_values got rdy=%b vld=%b a=%h b=%h eq=%b ae=%b gt=%b d=%0d want rdy=1 vld=0 rest 0",
                  in_ready, out_valid, out_a, out_b, exp_eq, exp_ae, exp_gt, exp_d);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_eq();
      res_t got, e;
      int lat;
      push_const('{a:16'h1234, b:16'h1234, eq:1'b1, ae:1'b1, gt:1'b0, d:4'd0});
      issue(16'h1234, 2'b00, 4'd0);
      collect(got, lat);
      pop_exp(e);
      checks++;
      if (lat !== 17) begin
         errors++;
         $display("FAIL eq_latency got %0d want 17", lat);
      end
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL eq_result got %h want %h", got, e);
      end
      release_out();
   endtask

   task automatic test_neg();
      res_t got, e;
      int lat;
      push_const('{a:16'h0005, b:16'hFFFB, eq:1'b0, ae:1'b1, gt:1'b1, d:4'd15});
      push_const('{a:16'h8000, b:16'h8000, eq:1'b1, ae:1'b1, gt:1'b0, d:4'd0});
      for (int k = 0; k < 2; k++) begin
         issue(k == 0 ? 16'h0005 : 16'h8000, 2'b01, 4'd0);
         collect(got, lat);
         pop_exp(e);
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL neg_result_%0d got %h want %h (lat %0d)", k, got, e, lat);
         end
         release_out();
      end
   endtask

   task automatic test_diff();
      res_t got, e;
      int lat;
`ifdef MFC_GEN_LFSR_EN
      for (int k = 0; k < 50; k++) begin
         model_push(16'h9796, 2'b10, 4'd15);
         issue(16'h9796, 2'b10, 4'd15);
         collect(got, lat);
         pop_exp(e);
         checks++;
         if ({got.b[15], got.gt, got.d, got.eq} !== {1'b0, 1'b0, 4'd15, 1'b0}) begin
            errors++;
            $display("FAIL diff15_flags_%0d got b15=%b gt=%b d=%0d eq=%b want 0 0 15 0",
                     k, got.b[15], got.gt, got.d, got.eq);
         end
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL diff15_model_%0d got %h want %h", k, got, e);
         end
         release_out();
      end
`else
      push_const('{a:16'h9796, b:16'h9600, eq:1'b0, ae:1'b0, gt:1'b1, d:4'd8});
      issue(16'h9796, 2'b10, 4'd8);
      collect(got, lat);
      pop_exp(e);
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL diff8_result got %h want %h", got, e);
      end
      release_out();
      push_const('{a:16'h1234, b:16'h0000, eq:1'b0, ae:1'b0, gt:1'b1, d:4'd12});
      issue(16'h1234, 2'b11, 4'd0);
      collect(got, lat);
      pop_exp(e);
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL rand_zero got %h want %h", got, e);
      end
      release_out();
`endif
   endtask

   task automatic test_mix();
      res_t got, e;
      int lat;
      logic [15:0] a;
      logic [1:0]  m;
      logic [3:0]  d;
      for (int k = 0; k < 12; k++) begin
         a = 16'($urandom);
         m = 2'(k % 4);
         d = 4'($urandom_range(0, 15));
         model_push(a, m, d);
         issue(a, m, d);
         collect(got, lat);
         pop_exp(e);
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL mix_%0d mode=%0d d=%0d got %h want %h", k, m, d, got, e);
         end
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      res_t got, e, held;
      int lat, n;
      bit stable;
      push_const('{a:16'h1234, b:16'h1234, eq:1'b1, ae:1'b1, gt:1'b0, d:4'd0});
      in_valid = 1'b1;
      in_a = 16'h1234;
      in_mode = 2'b00;
      in_d = 4'd0;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      in_a = 16'h0005;
      in_mode = 2'b01;
      collect(got, lat);
      pop_exp(e);
      checks++;
      if (got !== e || lat !== 17) begin
         errors++;
         $display("FAIL bp_first got %h lat %0d want %h lat 17", got, lat, e);
      end
      held = got;
      stable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if ({out_a, out_b, exp_eq, exp_ae, exp_gt, exp_d} !== held || !out_valid || in_ready)
            stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold got unstable want stable with in_ready=0");
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      end
      push_const('{a:16'h0005, b:16'hFFFB, eq:1'b0, ae:1'b1, gt:1'b1, d:4'd15});
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept got in_ready=%b want 0", in_ready);
      end
      collect(got, lat);
      pop_exp(e);
      checks++;
      if (got !== e || lat !== 17) begin
         errors++;
         $display("FAIL bp_second got %h lat %0d want %h lat 17", got, lat, e);
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      res_t got, e;
      int lat;
      bit early;
      issue(16'hABCD, 2'b01, 4'd0);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`ifdef MFC_GEN_LFSR_EN
      m_lfsr = 16'hACE1;
`endif
      checks++;
      if ({in_ready, out_valid, out_a, out_b, exp_eq, exp_ae, exp_gt, exp_d} !== {1'b1, 1'b0, 39'd0}) begin
         errors++;
         $display("FAIL midreset_values got rdy=%b vld=%b a=%h b=%h eq=%b ae=%b gt=%b d=%0d want rdy=1 vld=0 rest 0",
                  in_ready, out_valid, out_a, out_b, exp_eq, exp_ae, exp_gt, exp_d);
      end
      early = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("FAIL midreset_abort got out_valid=1 want 0");
      end
      push_const('{a:16'h4321, b:16'h4321, eq:1'b1, ae:1'b1, gt:1'b0, d:4'd0});
      issue(16'h4321, 2'b00, 4'd0);
      collect(got, lat);
      pop_exp(e);
      checks++;
      if (got !== e || lat !== 17) begin
         errors++;
         $display("FAIL midreset_fresh got %h lat %0d want %h lat 17", got, lat, e);
      end
      release_out();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_eq();
      test_neg();
      test_diff();
      test_mix();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
